mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer that shares one single-ported unified instruction/data memory between the pipeline's instruction-fetch port and its data (MEM-stage) port. It sits between the pipeline and the memory. It serialises accesses, sequences fixed-latency reads, returns one-cycle acknowledge pulses with registered read data, and drives stall signals so the pipeline freezes PC/IF_ID (fetch) or the downstream stages (data) until its access completes. Data accesses have priority; a starvation counter guarantees fetch progress.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from Mem_Re issue to Mem_RData valid (≥1)
- STARVE_MAX, 3, consecutive data grants with IF_Req pending before fetch is forced (≥1)

- Clk  in  1  clock, all state on rising edge
- Reset  in  1  synchronous, active-low reset
- IF_Req  in  1  fetch request, level, held until IF_Ack
- IF_Addr  in  ADDR_W  fetch address, stable while IF_Req
- IF_Ack  out  1  one-cycle pulse, IF_RData valid
- IF_RData  out  DATA_W  registered fetch data
- IF_Stall  out  1  IF_Req & ~IF_Ack (combinational)
- MEM_Req  in  1  data request, level, held until MEM_Ack
- MEM_Write  in  1  1 = store, 0 = load
- MEM_Addr  in  ADDR_W  data address
- MEM_WData  in  DATA_W  store data
- MEM_Ack  out  1  one-cycle completion pulse
- MEM_RData  out  DATA_W  registered load data
- MEM_Stall  out  1  MEM_Req & ~MEM_Ack (combinational)
- Mem_Re  out  1  memory read strobe, one cycle
- Mem_We  out  1  memory write strobe, one cycle
- Mem_Addr  out  ADDR_W  registered memory address
- Mem_WData  out  DATA_W  registered memory write data
- Mem_RData  in  DATA_W  memory read data, valid MEM_LAT cycles after Mem_Re

## Operation
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE: if any request is pending, grant and go to ISSUE; latch owner, address, write flag, and write data into Mem_* registers. Otherwise stay.
- Grant rule: MEM_Req alone → data; IF_Req alone → fetch; both → data, unless starve_cnt == STARVE_MAX, then fetch.
- starve_cnt: +1 on each data grant while IF_Req = 1. Cleared on a fetch grant, or in any IDLE cycle with IF_Req = 0. Saturates at STARVE_MAX.
- ISSUE (one cycle): Mem_Re = ~write, Mem_We = write.
  - Write: go to ACK.
  - Read: load lat_cnt = MEM_LAT−1; go to WAIT, or directly capture if MEM_LAT = 1.
- WAIT: decrement lat_cnt. When the cycle is the MEM_LAT-th after ISSUE, capture Mem_RData into the owner's RData register and go to ACK.
- ACK (one cycle): owner's Ack = 1, then go to IDLE. Requests are not sampled in ACK; the requester drops or changes Req on the following edge.
- RData registers hold their value until the next capture for the same port.
- A Req dropped mid-transaction does not abort it: the transaction completes and Ack still pulses.
- IF port is read-only. MEM_Write is ignored for fetch grants.

## Timing
- Reset (Reset = 0 at an edge): state IDLE, starve_cnt 0, lat_cnt 0.
  - All outputs 0: Acks, RData, Mem_Re, Mem_We, Mem_Addr, Mem_WData.
  - Stalls follow their combinational definition.
- Reset mid-transaction abandons it: no Ack, strobes low next cycle.
- Request first seen at the end of cycle 0 gives:
  - Strobe in cycle 1.
  - Read data sampled in cycle 1+MEM_LAT.
  - Ack in cycle 2+MEM_LAT for a read, or cycle 2 for a write.
  - IDLE in the next cycle.
- Read occupancy: MEM_LAT+3 cycles from request to next-grant sampling. Write occupancy: 3 cycles.
- Exactly one strobe per transaction. Mem_Re and Mem_We are never high together.
- At most one Ack per cycle. Never Ack for a port that was not granted.

## Test plan
- Reset: drive Reset = 0 with both Reqs high for 2 cycles → all Acks, strobes, and RData = 0; no grant until Reset = 1.
- Single fetch, MEM_LAT = 2:
  - Stimulus: IF_Addr = 0x40, IF_Req rises in cycle 0.
  - Required: Mem_Re = 1 and Mem_Addr = 0x40 in cycle 1. With Mem_RData = 0x2002000A in cycle 3: IF_Ack = 1 and IF_RData = 0x2002000A in cycle 4. IF_Stall is high in cycles 0–3.
- Data store:
  - Stimulus: MEM_Write = 1, MEM_Addr = 0x100, MEM_WData = 0xDEADBEEF.
  - Required: Mem_We = 1 with that address and data in cycle 1; Mem_Re = 0; MEM_Ack in cycle 2; IF_RData unchanged.
- Contention:
  - Stimulus: IF_Req and MEM_Req (load, addr 0x200) both high in cycle 0.
  - Required: data granted first (Mem_Addr = 0x200). Fetch issued in the cycle after MEM_Ack+1. IF_Stall stays high throughout.
- Starvation, STARVE_MAX = 3:
  - Stimulus: IF_Req held high while MEM_Req is continuously re-asserted.
  - Required: three data transactions, then a fetch grant even though MEM_Req = 1, then data again.
- Reset mid-read: Reset = 0 in WAIT → no IF_Ack ever for that access; next access after release issues normally with correct latency.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported memory between fetch and data ports;
//            data wins contention, a starvation counter forces fetch progress.
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              Clk_i,
  input  logic              Reset_i,
  input  logic              IF_Req_i,
  input  logic [ADDR_W-1:0] IF_Addr_i,
  output logic              IF_Ack_o,
  output logic [DATA_W-1:0] IF_RData_o,
  output logic              IF_Stall_o,
  input  logic              MEM_Req_i,
  input  logic              MEM_Write_i,
  input  logic [ADDR_W-1:0] MEM_Addr_i,
  input  logic [DATA_W-1:0] MEM_WData_i,
  output logic              MEM_Ack_o,
  output logic [DATA_W-1:0] MEM_RData_o,
  output logic              MEM_Stall_o,
  output logic              Mem_Re_o,
  output logic              Mem_We_o,
  output logic [ADDR_W-1:0] Mem_Addr_o,
  output logic [DATA_W-1:0] Mem_WData_o,
  input  logic [DATA_W-1:0] Mem_RData_i
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  logic [1:0]        state_q,     state_d;
  logic              own_data_q,  own_data_d;
  logic              write_q,     write_d;
  logic [LAT_W-1:0]  lat_cnt_q,   lat_cnt_d;
  logic [STV_W-1:0]  starve_q,    starve_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

  always_ff @(posedge Clk_i) begin
    if (!Reset_i) begin
      state_q     <= S_IDLE;
      own_data_q  <= 1'b0;
      write_q     <= 1'b0;
      lat_cnt_q   <= '0;
      starve_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      own_data_q  <= own_data_d;
      write_q     <= write_d;
      lat_cnt_q   <= lat_cnt_d;
      starve_q    <= starve_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    own_data_d  = own_data_q;
    write_d     = write_q;
    lat_cnt_d   = lat_cnt_q;
    starve_d    = starve_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (!IF_Req_i) starve_d = '0;
        // Data wins unless fetch has already lost STARVE_MAX grants in a row.
        if (MEM_Req_i && (!IF_Req_i || starve_q != STV_W'(STARVE_MAX))) begin
          own_data_d = 1'b1;
          write_d    = MEM_Write_i;
          addr_d     = MEM_Addr_i;
          wdata_d    = MEM_WData_i;
          state_d    = S_ISSUE;
          if (IF_Req_i && starve_q != STV_W'(STARVE_MAX))
            starve_d = starve_q + STV_W'(1);
        end else if (IF_Req_i) begin
          own_data_d = 1'b0;
          write_d    = 1'b0;
          addr_d     = IF_Addr_i;
          state_d    = S_ISSUE;
          starve_d   = '0;
        end
      end
      S_ISSUE: begin
        if (write_q) begin
          state_d = S_ACK;
        end else begin
          lat_cnt_d = LAT_W'(MEM_LAT - 1);
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_cnt_q == '0) begin
          if (own_data_q) mem_rdata_d = Mem_RData_i;
          else            if_rdata_d  = Mem_RData_i;
          state_d = S_ACK;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Mem_Re_o    = (state_q == S_ISSUE) && !write_q;
    Mem_We_o    = (state_q == S_ISSUE) &&  write_q;
    IF_Ack_o    = (state_q == S_ACK)   && !own_data_q;
    MEM_Ack_o   = (state_q == S_ACK)   &&  own_data_q;
    IF_Stall_o  = IF_Req_i  && !IF_Ack_o;
    MEM_Stall_o = MEM_Req_i && !MEM_Ack_o;
    Mem_Addr_o  = addr_q;
    Mem_WData_o = wdata_q;
    IF_RData_o  = if_rdata_q;
    MEM_RData_o = mem_rdata_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Scoreboard bench: transaction-level arbiter model plus a
//            latency memory model; monitor compares every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MEM_LAT = 2;
  localparam int STARVE_MAX = 3;

  logic clk = 1'b0;
  logic reset, if_req, if_ack, if_stall, mem_req, mem_write, mem_ack, mem_stall;
  logic m_re, m_we;
  logic [AW-1:0] if_addr, mem_addr_in, m_addr;
  logic [DW-1:0] if_rdata, mem_wdata_in, mem_rdata, m_wdata, m_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .Clk_i(clk), .Reset_i(reset),
    .IF_Req_i(if_req), .IF_Addr_i(if_addr), .IF_Ack_o(if_ack), .IF_RData_o(if_rdata),
    .IF_Stall_o(if_stall),
    .MEM_Req_i(mem_req), .MEM_Write_i(mem_write), .MEM_Addr_i(mem_addr_in),
    .MEM_WData_i(mem_wdata_in), .MEM_Ack_o(mem_ack), .MEM_RData_o(mem_rdata),
    .MEM_Stall_o(mem_stall),
    .Mem_Re_o(m_re), .Mem_We_o(m_we), .Mem_Addr_o(m_addr), .Mem_WData_o(m_wdata),
    .Mem_RData_i(m_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic write; logic [31:0] addr; logic [31:0] wdata; int gap; } req_t;
  typedef struct { int cyc; logic re; logic we; logic [31:0] addr; logic [31:0] wdata; } strobe_t;
  typedef struct { int cyc; logic port_if; logic is_read; logic [31:0] rdata; } ack_t;

  req_t    if_q[$], mem_q[$];
  strobe_t strobe_q[$];
  ack_t    ack_q[$];
  logic [31:0] rd_pipe[int];

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  int  free_at = 0;
  int  starve = 0;
  int  rst_req = 0;
  int  rst_done = 0;
  bit  drop_en = 0;
  bit  if_act = 0, if_granted = 0, mem_act = 0, mem_granted = 0;
  int  if_ack_cyc = 0, mem_ack_cyc = 0, if_grant_cyc = 0, mem_grant_cyc = 0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h40) return 32'h2002000A;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%08h required=0x%08h", name, cyc, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory: read data is only meaningful exactly MEM_LAT cycles after Mem_Re.
  initial begin
    m_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (m_re === 1'b1) rd_pipe[cyc + MEM_LAT] = m_addr;
      if (rd_pipe.exists(cyc)) begin
        m_rdata = mem_f(rd_pipe[cyc]);
        rd_pipe.delete(cyc);
      end else begin
        m_rdata = $urandom;
      end
    end
  end

  task automatic grant(input int n, input bit to_data);
    logic w;
    logic [31:0] a, d;
    int ack_c;
    w = to_data ? mem_write : 1'b0;
    a = to_data ? mem_addr_in : if_addr;
    d = mem_wdata_in;
    ack_c = w ? n + 2 : n + 2 + MEM_LAT;
    strobe_q.push_back('{n + 1, !w, w, a, d});
    ack_q.push_back('{ack_c, !to_data, !w, mem_f(a)});
    free_at = ack_c + 1;
    if (to_data) begin mem_granted = 1; mem_ack_cyc = ack_c; mem_grant_cyc = n; end
    else         begin if_granted  = 1; if_ack_cyc  = ack_c; if_grant_cyc  = n; end
  endtask

  // Driver + transaction-level reference model.
  initial begin
    req_t t;
    int n;
    reset = 1'b0; if_req = 1'b1; mem_req = 1'b1;
    if_addr = 32'h0; mem_write = 1'b0; mem_addr_in = 32'h0; mem_wdata_in = 32'h0;
    forever begin
      @(posedge clk); #2;
      n = cyc;
      if (n == 4) begin if_req = 1'b0; mem_req = 1'b0; end
      if (if_act && if_granted && n == if_ack_cyc)   begin if_act = 0;  if_req = 1'b0;  end
      if (mem_act && mem_granted && n == mem_ack_cyc) begin mem_act = 0; mem_req = 1'b0; end
      if (n <= 3) reset = 1'b0;
      else if (rst_done < rst_req) begin reset = 1'b0; rst_done++; end
      else reset = 1'b1;
      if (!if_act && if_q.size() > 0) begin
        t = if_q[0];
        if (t.gap > 0) begin t.gap--; if_q[0] = t; end
        else begin
          void'(if_q.pop_front());
          if_req = 1'b1; if_addr = t.addr; if_act = 1; if_granted = 0;
        end
      end
      if (!mem_act && mem_q.size() > 0) begin
        t = mem_q[0];
        if (t.gap > 0) begin t.gap--; mem_q[0] = t; end
        else begin
          void'(mem_q.pop_front());
          mem_req = 1'b1; mem_write = t.write; mem_addr_in = t.addr; mem_wdata_in = t.wdata;
          mem_act = 1; mem_granted = 0;
        end
      end
      // Requesters may abandon Req once granted; the access must still finish.
      if (drop_en && if_act && if_granted && n > if_grant_cyc && $urandom_range(0, 3) == 0)
        if_req = 1'b0;
      if (drop_en && mem_act && mem_granted && n > mem_grant_cyc && $urandom_range(0, 3) == 0)
        mem_req = 1'b0;
      if (!reset) begin
        while (strobe_q.size() > 0 && strobe_q[$].cyc > n) void'(strobe_q.pop_back());
        while (ack_q.size() > 0 && ack_q[$].cyc > n) void'(ack_q.pop_back());
        free_at = n + 1;
        starve = 0;
        if (if_act && if_granted)   begin if_granted = 0;  if_req = 1'b1;  end
        if (mem_act && mem_granted) begin mem_granted = 0; mem_req = 1'b1; end
      end else if (n >= free_at) begin
        if (mem_req && (!if_req || starve < STARVE_MAX)) begin
          grant(n, 1'b1);
          starve = if_req ? starve + 1 : 0;
        end else if (if_req) begin
          grant(n, 1'b0);
          starve = 0;
        end else begin
          starve = 0;
        end
      end
    end
  end

  // Monitor: pops expectations when their cycle arrives; otherwise expects quiet.
  initial begin
    logic [31:0] exp_if_rd, exp_mem_rd;
    logic e_if_ack, e_mem_ack, e_re, e_we;
    ack_t a;
    strobe_t s;
    bit have_s;
    exp_if_rd = '0; exp_mem_rd = '0;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        e_if_ack = 0; e_mem_ack = 0;
        if (ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
          a = ack_q.pop_front();
          if (a.port_if) begin e_if_ack = 1; exp_if_rd = a.rdata; end
          else begin
            e_mem_ack = 1;
            if (a.is_read) exp_mem_rd = a.rdata;
          end
        end
        check("if_ack", 32'(if_ack), 32'(e_if_ack));
        check("mem_ack", 32'(mem_ack), 32'(e_mem_ack));
        check("if_rdata", if_rdata, exp_if_rd);
        check("mem_rdata", mem_rdata, exp_mem_rd);
        check("if_stall", 32'(if_stall), 32'(if_req & ~e_if_ack));
        check("mem_stall", 32'(mem_stall), 32'(mem_req & ~e_mem_ack));
        have_s = 0; e_re = 0; e_we = 0;
        if (strobe_q.size() > 0 && strobe_q[0].cyc == cyc) begin
          s = strobe_q.pop_front(); have_s = 1; e_re = s.re; e_we = s.we;
        end
        check("mem_re", 32'(m_re), 32'(e_re));
        check("mem_we", 32'(m_we), 32'(e_we));
        if (have_s) begin
          check("mem_addr", m_addr, s.addr);
          if (s.we) check("mem_wdata", m_wdata, s.wdata);
        end
        if (!reset) begin exp_if_rd = '0; exp_mem_rd = '0; end
      end
    end
  end

  function automatic bit all_idle();
    return if_q.size() == 0 && mem_q.size() == 0 && !if_act && !mem_act && cyc >= free_at;
  endfunction

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      if (all_idle()) return;
    end
    check("idle_timeout", 32'(all_idle()), 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_mem_addr", m_addr, 32'h0);
    check("reset_mem_wdata", m_wdata, 32'h0);
    repeat (4) @(posedge clk);

    if_q.push_back('{1'b0, 32'h40, 32'h0, 0});
    wait_idle(50);
    mem_q.push_back('{1'b1, 32'h100, 32'hDEADBEEF, 0});
    wait_idle(50);
    if_q.push_back('{1'b0, 32'h80, 32'h0, 0});
    mem_q.push_back('{1'b0, 32'h200, 32'h0, 0});
    wait_idle(50);
    if_q.push_back('{1'b0, 32'h300, 32'h0, 0});
    for (int i = 0; i < 5; i++) mem_q.push_back('{1'b0, 32'h400 + 32'(4 * i), 32'h0, 0});
    wait_idle(100);

    // Abandon a fetch while it waits for memory data.
    if_q.push_back('{1'b0, 32'h500, 32'h0, 0});
    for (int k = 0; k < 20 && !if_granted; k++) @(posedge clk);
    check("midread_granted", 32'(if_granted), 32'd1);
    repeat (2) @(posedge clk);
    rst_req = rst_req + 1;
    wait_idle(50);

    drop_en = 1;
    for (int i = 0; i < 120; i++) begin
      if_q.push_back('{1'b0, $urandom & 32'hFFFF_FFFC, 32'h0, int'($urandom_range(0, 4))});
      mem_q.push_back('{1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
                        int'($urandom_range(0, 4))});
    end
    for (int k = 0; k < 20000 && !all_idle(); k++) begin
      @(posedge clk);
      if ($urandom_range(0, 299) == 0) rst_req = rst_req + int'($urandom_range(1, 2));
    end
    check("random_done", 32'(all_idle()), 32'd1);
    repeat (10) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
